// File: rtl/csr_file_unit.sv
// Machine-mode CSR file: Zicsr read-modify-write, mcycle/minstret counters,
// and trap-entry / MRET sequencing of mstatus, mepc, mcause and mtval.
module csr_file_unit #(
   parameter int unsigned     XLEN          = 32,
   parameter int unsigned     COUNTER_WIDTH = 64,
   parameter logic [XLEN-1:0] HART_ID       = '0,
   parameter logic [XLEN-1:0] MTVEC_RESET   = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_valid,
   input  logic [1:0]      csr_op,
   input  logic            csr_imm,
   input  logic [11:0]     csr_addr,
   input  logic [4:0]      rs1_addr,
   input  logic [XLEN-1:0] rs1_value,
   output logic [XLEN-1:0] rd_value,
   output logic            csr_illegal,
   input  logic            instr_retire,
   input  logic            trap_enter,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_val,
   input  logic            mret,
   output logic [XLEN-1:0] mtvec_out,
   output logic [XLEN-1:0] mepc_out,
   output logic            mie_global
);

   localparam int unsigned CH = COUNTER_WIDTH - 32;

   localparam logic [1:0] OP_NONE = 2'd0;
   localparam logic [1:0] OP_RW   = 2'd1;
   localparam logic [1:0] OP_RS   = 2'd2;
   localparam logic [1:0] OP_RC   = 2'd3;

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MTVAL     = 12'h343;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
   localparam logic [11:0] A_MVENDORID = 12'hF11;
   localparam logic [11:0] A_MARCHID   = 12'hF12;
   localparam logic [11:0] A_MIMPID    = 12'hF13;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam logic [XLEN-1:0]          ALIGN4  = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

   logic                     mstatus_mie_q,  mstatus_mie_d;
   logic                     mstatus_mpie_q, mstatus_mpie_d;
   logic [XLEN-1:0]          mie_csr_q,  mie_csr_d;
   logic [XLEN-1:0]          mtvec_q,    mtvec_d;
   logic [XLEN-1:0]          mscratch_q, mscratch_d;
   logic [XLEN-1:0]          mepc_q,     mepc_d;
   logic [XLEN-1:0]          mcause_q,   mcause_d;
   logic [XLEN-1:0]          mtval_q,    mtval_d;
   logic [COUNTER_WIDTH-1:0] mcycle_q,   mcycle_d;
   logic [COUNTER_WIDTH-1:0] minstret_q, minstret_d;

   logic [XLEN-1:0] csr_rdata;
   logic            addr_impl;
   logic [XLEN-1:0] operand;
   logic [XLEN-1:0] wdata;
   logic            write_intent;
   logic            illegal;
   logic            csr_we;

   always_comb begin
      csr_rdata = '0;
      addr_impl = 1'b1;
      case (csr_addr)
         A_MSTATUS: begin
            csr_rdata[12:11] = 2'b11;
            csr_rdata[7]     = mstatus_mpie_q;
            csr_rdata[3]     = mstatus_mie_q;
         end
         A_MIE:                   csr_rdata = mie_csr_q;
         A_MTVEC:                 csr_rdata = mtvec_q;
         A_MSCRATCH:              csr_rdata = mscratch_q;
         A_MEPC:                  csr_rdata = mepc_q;
         A_MCAUSE:                csr_rdata = mcause_q;
         A_MTVAL:                 csr_rdata = mtval_q;
         A_MCYCLE,   A_CYCLE:     csr_rdata[31:0]   = mcycle_q[31:0];
         A_MCYCLEH,  A_CYCLEH:    csr_rdata[CH-1:0] = mcycle_q[COUNTER_WIDTH-1:32];
         A_MINSTRET, A_INSTRET:   csr_rdata[31:0]   = minstret_q[31:0];
         A_MINSTRETH, A_INSTRETH: csr_rdata[CH-1:0] = minstret_q[COUNTER_WIDTH-1:32];
         A_MVENDORID, A_MARCHID, A_MIMPID: csr_rdata = '0;
         A_MHARTID:               csr_rdata = HART_ID;
         default:                 addr_impl = 1'b0;
      endcase
   end

   // RS/RC with x0 / uimm=0 are pure reads, which keeps read-only CSRs readable.
   always_comb begin
      operand      = csr_imm ? {{(XLEN-5){1'b0}}, rs1_addr} : rs1_value;
      write_intent = (csr_op == OP_RW) ||
                     (((csr_op == OP_RS) || (csr_op == OP_RC)) && (rs1_addr != 5'd0));
      case (csr_op)
         OP_RW:   wdata = operand;
         OP_RS:   wdata = csr_rdata | operand;
         OP_RC:   wdata = csr_rdata & ~operand;
         default: wdata = csr_rdata;
      endcase
      illegal = csr_valid && (csr_op != OP_NONE) &&
                (!addr_impl || ((csr_addr[11:10] == 2'b11) && write_intent));
      csr_we  = csr_valid && write_intent && !illegal && !trap_enter;
   end

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_csr_d      = mie_csr_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      mcycle_d       = mcycle_q + CNT_ONE;
      minstret_d     = instr_retire ? (minstret_q + CNT_ONE) : minstret_q;
      if (trap_enter) begin
         mepc_d         = trap_pc & ALIGN4;
         mcause_d       = trap_cause;
         mtval_d        = trap_val;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else begin
         // A counter-half write replaces the incremented value for that counter.
         if (csr_we) begin
            case (csr_addr)
               A_MSTATUS: begin
                  mstatus_mie_d  = wdata[3];
                  mstatus_mpie_d = wdata[7];
               end
               A_MIE:      mie_csr_d  = wdata;
               A_MTVEC:    mtvec_d    = wdata & ALIGN4;
               A_MSCRATCH: mscratch_d = wdata;
               A_MEPC:     mepc_d     = wdata & ALIGN4;
               A_MCAUSE:   mcause_d   = wdata;
               A_MTVAL:    mtval_d    = wdata;
               A_MCYCLE: begin
                  mcycle_d        = mcycle_q;
                  mcycle_d[31:0]  = wdata[31:0];
               end
               A_MCYCLEH: begin
                  mcycle_d                      = mcycle_q;
                  mcycle_d[COUNTER_WIDTH-1:32]  = wdata[CH-1:0];
               end
               A_MINSTRET: begin
                  minstret_d       = minstret_q;
                  minstret_d[31:0] = wdata[31:0];
               end
               A_MINSTRETH: begin
                  minstret_d                     = minstret_q;
                  minstret_d[COUNTER_WIDTH-1:32] = wdata[CH-1:0];
               end
               default: ;
            endcase
         end
         if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_csr_q      <= '0;
         mtvec_q        <= MTVEC_RESET & ALIGN4;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mcycle_q       <= '0;
         minstret_q     <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_csr_q      <= mie_csr_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         mcycle_q       <= mcycle_d;
         minstret_q     <= minstret_d;
      end
   end

   assign rd_value    = csr_valid ? csr_rdata : '0;
   assign csr_illegal = illegal;
   assign mtvec_out   = mtvec_q;
   assign mepc_out    = mepc_q;
   assign mie_global  = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file_unit.sv
// Bench for csr_file_unit: directed scenarios plus randomized traffic checked
// against a behavioural CSR model holding whole 64-bit counters and mstatus bits.
module tb_csr_file_unit;

   localparam logic [31:0] TB_HART  = 32'h0000_0003;
   localparam logic [31:0] TB_MTVEC = 32'h0000_1003;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_valid;
   logic [1:0]  csr_op;
   logic        csr_imm;
   logic [11:0] csr_addr;
   logic [4:0]  rs1_addr;
   logic [31:0] rs1_value;
   logic [31:0] rd_value;
   logic        csr_illegal;
   logic        instr_retire;
   logic        trap_enter;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic [31:0] trap_val;
   logic        mret;
   logic [31:0] mtvec_out;
   logic [31:0] mepc_out;
   logic        mie_global;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   logic [31:0] obs_rd, exp_rd;
   logic        obs_ill, exp_ill;

   // reference model state
   logic        m_mie, m_mpie;
   logic [31:0] m_miereg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_cyc, m_ins;

   csr_file_unit #(
      .XLEN(32), .COUNTER_WIDTH(64), .HART_ID(TB_HART), .MTVEC_RESET(TB_MTVEC)
   ) dut (
      .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_op(csr_op), .csr_imm(csr_imm),
      .csr_addr(csr_addr), .rs1_addr(rs1_addr), .rs1_value(rs1_value),
      .rd_value(rd_value), .csr_illegal(csr_illegal), .instr_retire(instr_retire),
      .trap_enter(trap_enter), .trap_pc(trap_pc), .trap_cause(trap_cause),
      .trap_val(trap_val), .mret(mret), .mtvec_out(mtvec_out), .mepc_out(mepc_out),
      .mie_global(mie_global)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic m_reset();
      m_mie = 1'b0; m_mpie = 1'b0;
      m_miereg = '0; m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
      m_mtvec = TB_MTVEC & 32'hFFFF_FFFC;
      m_cyc = '0; m_ins = '0;
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a, output bit impl);
      impl = 1'b1;
      case (a)
         12'h300: m_read = {19'd0, 2'b11, 3'd0, m_mpie, 3'd0, m_mie, 3'd0};
         12'h304: m_read = m_miereg;
         12'h305: m_read = m_mtvec;
         12'h340: m_read = m_mscratch;
         12'h341: m_read = m_mepc;
         12'h342: m_read = m_mcause;
         12'h343: m_read = m_mtval;
         12'hB00, 12'hC00: m_read = m_cyc[31:0];
         12'hB80, 12'hC80: m_read = m_cyc[63:32];
         12'hB02, 12'hC02: m_read = m_ins[31:0];
         12'hB82, 12'hC82: m_read = m_ins[63:32];
         12'hF11, 12'hF12, 12'hF13: m_read = 32'd0;
         12'hF14: m_read = TB_HART;
         default: begin impl = 1'b0; m_read = 32'd0; end
      endcase
   endfunction

   function automatic bit m_intent();
      return (csr_op == 2'd1) || (csr_op != 2'd0 && rs1_addr != 5'd0);
   endfunction

   task automatic m_expect(output logic [31:0] rd, output logic ill);
      bit          impl;
      logic [31:0] v;
      v   = m_read(csr_addr, impl);
      rd  = csr_valid ? v : 32'd0;
      ill = csr_valid && csr_op != 2'd0 &&
            (!impl || (csr_addr[11:10] == 2'b11 && m_intent()));
   endtask

   task automatic m_update();
      bit          impl, we;
      logic [31:0] old, opnd, nv, rd_unused;
      logic        ill, old_mie, old_mpie;
      logic [63:0] cyc_n, ins_n;
      if (rst) begin
         m_reset();
         return;
      end
      old = m_read(csr_addr, impl);
      m_expect(rd_unused, ill);
      we   = csr_valid && m_intent() && !ill && !trap_enter;
      opnd = csr_imm ? {27'd0, rs1_addr} : rs1_value;
      nv   = (csr_op == 2'd1) ? opnd : (csr_op == 2'd2) ? (old | opnd) : (old & ~opnd);
      cyc_n = m_cyc + 64'd1;
      ins_n = m_ins + (instr_retire ? 64'd1 : 64'd0);
      old_mie = m_mie; old_mpie = m_mpie;
      if (trap_enter) begin
         m_mepc = trap_pc & 32'hFFFF_FFFC; m_mcause = trap_cause; m_mtval = trap_val;
         m_mpie = old_mie; m_mie = 1'b0;
      end else begin
         if (we) begin
            case (csr_addr)
               12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
               12'h304: m_miereg = nv;
               12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
               12'h340: m_mscratch = nv;
               12'h341: m_mepc = nv & 32'hFFFF_FFFC;
               12'h342: m_mcause = nv;
               12'h343: m_mtval = nv;
               12'hB00: cyc_n = {m_cyc[63:32], nv};
               12'hB80: cyc_n = {nv, m_cyc[31:0]};
               12'hB02: ins_n = {m_ins[63:32], nv};
               12'hB82: ins_n = {nv, m_ins[31:0]};
               default: ;
            endcase
         end
         if (mret) begin m_mie = old_mpie; m_mpie = 1'b1; end
      end
      m_cyc = cyc_n;
      m_ins = ins_n;
   endtask

   task automatic step();
      @(negedge clk);
      obs_rd  = rd_value;
      obs_ill = csr_illegal;
      m_expect(exp_rd, exp_ill);
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic clear_inputs();
      csr_valid = 1'b0; csr_op = 2'd0; csr_imm = 1'b0; csr_addr = '0;
      rs1_addr = '0; rs1_value = '0; instr_retire = 1'b0; trap_enter = 1'b0;
      trap_pc = '0; trap_cause = '0; trap_val = '0; mret = 1'b0;
   endtask

   task automatic drive_csr(input logic [1:0] op, input logic imm, input logic [11:0] a,
                            input logic [4:0] r1a, input logic [31:0] r1v);
      csr_valid = 1'b1; csr_op = op; csr_imm = imm; csr_addr = a;
      rs1_addr = r1a; rs1_value = r1v;
   endtask

   task automatic test_reset();
      clear_inputs(); rst = 1'b1; step(); step(); rst = 1'b0;
      n_total++; if (mtvec_out !== 32'h0000_1000) $display("FAIL reset_mtvec_out: got %h want %h", mtvec_out, 32'h1000); else n_pass++;
      n_total++; if (mepc_out !== 32'd0) $display("FAIL reset_mepc_out: got %h want 0", mepc_out); else n_pass++;
      n_total++; if (mie_global !== 1'b0) $display("FAIL reset_mie_global: got %b want 0", mie_global); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'h305, 5'd0, 32'hFFFF_FFFF); step();
      n_total++; if (obs_rd !== 32'h0000_1000) $display("FAIL reset_mtvec_read: got %h want %h", obs_rd, 32'h1000); else n_pass++;
      n_total++; if (obs_ill !== 1'b0) $display("FAIL reset_mtvec_legal: got %b want 0", obs_ill); else n_pass++;
      n_total++; if (mtvec_out !== 32'h0000_1000) $display("FAIL reset_mtvec_nowrite: got %h want %h", mtvec_out, 32'h1000); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'hF14, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== TB_HART) $display("FAIL hartid_read: got %h want %h", obs_rd, TB_HART); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'h300, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'h0000_1800) $display("FAIL reset_mstatus: got %h want %h", obs_rd, 32'h1800); else n_pass++;
   endtask

   task automatic test_rw_rs_rc();
      drive_csr(2'd1, 1'b0, 12'h340, 5'd1, 32'hDEAD_BEEF); step();
      n_total++; if (obs_rd !== 32'd0) $display("FAIL rw_old_mscratch: got %h want 0", obs_rd); else n_pass++;
      drive_csr(2'd3, 1'b0, 12'h340, 5'd2, 32'h0000_00FF); step();
      n_total++; if (obs_rd !== 32'hDEAD_BEEF) $display("FAIL rc_old_mscratch: got %h want %h", obs_rd, 32'hDEAD_BEEF); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'h340, 5'd0, 32'hFFFF_FFFF); step();
      n_total++; if (obs_rd !== 32'hDEAD_BE00) $display("FAIL rc_result: got %h want %h", obs_rd, 32'hDEAD_BE00); else n_pass++;
      drive_csr(2'd2, 1'b1, 12'h340, 5'd17, 32'd0); step();
      drive_csr(2'd2, 1'b0, 12'h340, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'hDEAD_BE11) $display("FAIL rsi_result: got %h want %h", obs_rd, 32'hDEAD_BE11); else n_pass++;
      drive_csr(2'd1, 1'b0, 12'h341, 5'd3, 32'h0000_1237); step();
      n_total++; if (mepc_out !== 32'h0000_1234) $display("FAIL mepc_align: got %h want %h", mepc_out, 32'h1234); else n_pass++;
      clear_inputs(); csr_addr = 12'h340; step();
      n_total++; if (obs_rd !== 32'd0) $display("FAIL rd_when_invalid: got %h want 0", obs_rd); else n_pass++;
   endtask

   task automatic test_illegal();
      drive_csr(2'd1, 1'b1, 12'hC00, 5'd5, 32'd0); step();
      n_total++; if (obs_ill !== 1'b1) $display("FAIL ro_write_illegal: got %b want 1", obs_ill); else n_pass++;
      n_total++; if (obs_rd !== exp_rd) $display("FAIL ro_write_rd: got %h want %h", obs_rd, exp_rd); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'hC00, 5'd0, 32'd0); step();
      n_total++; if (obs_ill !== 1'b0) $display("FAIL ro_read_legal: got %b want 0", obs_ill); else n_pass++;
      n_total++; if (obs_rd !== exp_rd) $display("FAIL cycle_unchanged: got %h want %h", obs_rd, exp_rd); else n_pass++;
      drive_csr(2'd1, 1'b0, 12'h7C0, 5'd1, 32'h1234_5678); step();
      n_total++; if (obs_ill !== 1'b1) $display("FAIL unimpl_illegal: got %b want 1", obs_ill); else n_pass++;
      n_total++; if (obs_rd !== 32'd0) $display("FAIL unimpl_rd: got %h want 0", obs_rd); else n_pass++;
      drive_csr(2'd0, 1'b0, 12'h7C0, 5'd1, 32'd0); step();
      n_total++; if (obs_ill !== 1'b0) $display("FAIL op_none_legal: got %b want 0", obs_ill); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'hF14, 5'd3, 32'hFFFF_FFFF); step();
      n_total++; if (obs_ill !== 1'b1) $display("FAIL hartid_set_illegal: got %b want 1", obs_ill); else n_pass++;
      n_total++; if (obs_rd !== TB_HART) $display("FAIL hartid_illegal_rd: got %h want %h", obs_rd, TB_HART); else n_pass++;
   endtask

   task automatic test_counters();
      drive_csr(2'd1, 1'b0, 12'hB80, 5'd1, 32'hFFFF_FFFF); step();
      drive_csr(2'd1, 1'b0, 12'hB00, 5'd1, 32'hFFFF_FFFF); step();
      drive_csr(2'd2, 1'b0, 12'hB00, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'hFFFF_FFFF) $display("FAIL mcycle_allones: got %h want %h", obs_rd, 32'hFFFF_FFFF); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'hB80, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'd0) $display("FAIL mcycle_wrap: got %h want 0", obs_rd); else n_pass++;
      drive_csr(2'd1, 1'b0, 12'hB00, 5'd1, 32'hFFFF_FFFF); step();
      drive_csr(2'd1, 1'b0, 12'hB80, 5'd1, 32'd0); step();
      drive_csr(2'd2, 1'b0, 12'hB80, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'd0) $display("FAIL mcycleh_written: got %h want 0", obs_rd); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'hB00, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'd0) $display("FAIL mcycle_carry_lo: got %h want 0", obs_rd); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'hC80, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'd1) $display("FAIL mcycle_carry_hi: got %h want 1", obs_rd); else n_pass++;
      drive_csr(2'd1, 1'b0, 12'hB02, 5'd1, 32'd7); instr_retire = 1'b1; step();
      drive_csr(2'd2, 1'b0, 12'hB02, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'd7) $display("FAIL minstret_write_wins: got %h want 7", obs_rd); else n_pass++;
      instr_retire = 1'b0;
      drive_csr(2'd2, 1'b0, 12'hC02, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'd8) $display("FAIL minstret_increment: got %h want 8", obs_rd); else n_pass++;
   endtask

   task automatic test_trap_mret();
      clear_inputs();
      drive_csr(2'd1, 1'b0, 12'h340, 5'd1, 32'h0000_1234); step();
      drive_csr(2'd2, 1'b0, 12'h300, 5'd1, 32'h0000_0008); step();
      n_total++; if (mie_global !== 1'b1) $display("FAIL set_mie: got %b want 1", mie_global); else n_pass++;
      drive_csr(2'd1, 1'b0, 12'h340, 5'd2, 32'h0000_FFFF);
      trap_enter = 1'b1; trap_pc = 32'h103; trap_cause = 32'h8000_000B; trap_val = 32'h55; step();
      clear_inputs();
      n_total++; if (mepc_out !== 32'h100) $display("FAIL trap_mepc: got %h want %h", mepc_out, 32'h100); else n_pass++;
      n_total++; if (mie_global !== 1'b0) $display("FAIL trap_mie: got %b want 0", mie_global); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'h342, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'h8000_000B) $display("FAIL trap_mcause: got %h want %h", obs_rd, 32'h8000_000B); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'h343, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'h55) $display("FAIL trap_mtval: got %h want %h", obs_rd, 32'h55); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'h300, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'h1880) $display("FAIL trap_mstatus: got %h want %h", obs_rd, 32'h1880); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'h340, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'h1234) $display("FAIL trap_drops_write: got %h want %h", obs_rd, 32'h1234); else n_pass++;
      clear_inputs(); mret = 1'b1; step(); mret = 1'b0;
      n_total++; if (mie_global !== 1'b1) $display("FAIL mret_mie: got %b want 1", mie_global); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'h300, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'h1888) $display("FAIL mret_mstatus: got %h want %h", obs_rd, 32'h1888); else n_pass++;
      clear_inputs(); trap_enter = 1'b1; mret = 1'b1; trap_pc = 32'h2000; trap_cause = 32'd2; step();
      clear_inputs();
      n_total++; if (mie_global !== 1'b0) $display("FAIL trap_beats_mret: got %b want 0", mie_global); else n_pass++;
      n_total++; if (mepc_out !== 32'h2000) $display("FAIL trap_mret_mepc: got %h want %h", mepc_out, 32'h2000); else n_pass++;
      drive_csr(2'd1, 1'b0, 12'h300, 5'd1, 32'd0); mret = 1'b1; step(); mret = 1'b0;
      drive_csr(2'd2, 1'b0, 12'h300, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'h1888) $display("FAIL mret_beats_write: got %h want %h", obs_rd, 32'h1888); else n_pass++;
   endtask

   task automatic test_mid_reset();
      clear_inputs();
      drive_csr(2'd1, 1'b0, 12'h340, 5'd1, 32'h0000_AAAA); step();
      drive_csr(2'd1, 1'b0, 12'h305, 5'd1, 32'h0000_4000); step();
      drive_csr(2'd1, 1'b0, 12'h340, 5'd1, 32'h0000_5555);
      rst = 1'b1; trap_enter = 1'b1; trap_pc = 32'h800; mret = 1'b1; instr_retire = 1'b1; step();
      rst = 1'b0; clear_inputs();
      n_total++; if (mtvec_out !== 32'h1000) $display("FAIL midrst_mtvec: got %h want %h", mtvec_out, 32'h1000); else n_pass++;
      n_total++; if (mepc_out !== 32'd0) $display("FAIL midrst_mepc: got %h want 0", mepc_out); else n_pass++;
      n_total++; if (mie_global !== 1'b0) $display("FAIL midrst_mie: got %b want 0", mie_global); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'h340, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'd0) $display("FAIL midrst_mscratch: got %h want 0", obs_rd); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'hB00, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'd1) $display("FAIL midrst_mcycle: got %h want 1", obs_rd); else n_pass++;
      drive_csr(2'd2, 1'b0, 12'hB02, 5'd0, 32'd0); step();
      n_total++; if (obs_rd !== 32'd0) $display("FAIL midrst_minstret: got %h want 0", obs_rd); else n_pass++;
   endtask

   task automatic test_random();
      logic [11:0] pool [20] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                                 12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0};
      for (int i = 0; i < 500; i++) begin
         csr_valid    = ($urandom_range(0, 3) != 0);
         csr_op       = 2'($urandom);
         csr_imm      = 1'($urandom);
         csr_addr     = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 19)];
         rs1_addr     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         rs1_value    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         instr_retire = 1'($urandom);
         trap_enter   = ($urandom_range(0, 15) == 0);
         mret         = ($urandom_range(0, 7) == 0);
         trap_pc      = $urandom;
         trap_cause   = $urandom;
         trap_val     = $urandom;
         rst          = ($urandom_range(0, 63) == 0);
         step();
         n_total++; if (obs_rd !== exp_rd) $display("FAIL rand_rd[%0d]: got %h want %h", i, obs_rd, exp_rd); else n_pass++;
         n_total++; if (obs_ill !== exp_ill) $display("FAIL rand_illegal[%0d]: got %b want %b", i, obs_ill, exp_ill); else n_pass++;
         n_total++; if (mtvec_out !== m_mtvec) $display("FAIL rand_mtvec[%0d]: got %h want %h", i, mtvec_out, m_mtvec); else n_pass++;
         n_total++; if (mepc_out !== m_mepc) $display("FAIL rand_mepc[%0d]: got %h want %h", i, mepc_out, m_mepc); else n_pass++;
         n_total++; if (mie_global !== m_mie) $display("FAIL rand_mie[%0d]: got %b want %b", i, mie_global, m_mie); else n_pass++;
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      m_reset();
      test_reset();
      test_rw_rs_rc();
      test_illegal();
      test_counters();
      test_trap_mret();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/csr_file_unit.md
Name: csr_file_unit

Overview:
- Machine-mode CSR register file plus Zicsr read-modify-write execution, with cycle/instret counters and trap-entry/MRET state updates.
- Sits in the execute stage. Combinational read feeds rd_value. All CSR state updates on the clock edge.
- Replaces stateless CSR op decoding with owned, parametrised CSR storage, illegal-access detection and trap sequencing.

Parameters:
- XLEN, 32, data width of CSRs and operands.
- COUNTER_WIDTH, 64, width of mcycle/minstret (legal 33..64); high halves expose bits [COUNTER_WIDTH-1:32], zero-padded.
- HART_ID, 0, value returned by mhartid.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (bits[1:0] forced 0).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- csr_valid  input  1  CSR instruction present this cycle
- csr_op  input  2  0 none, 1 RW, 2 RS, 3 RC
- csr_imm  input  1  1: operand = zero-extended rs1_addr (uimm)
- csr_addr  input  12  CSR address
- rs1_addr  input  5  rs1 index / uimm
- rs1_value  input  XLEN  rs1 data
- rd_value  output  XLEN  old CSR value (combinational)
- csr_illegal  output  1  illegal access this cycle (combinational)
- instr_retire  input  1  one instruction retires this cycle
- trap_enter  input  1  take trap this cycle
- trap_pc  input  XLEN  faulting PC
- trap_cause  input  XLEN  mcause value
- trap_val  input  XLEN  mtval value
- mret  input  1  execute MRET this cycle
- mtvec_out  output  XLEN  current mtvec
- mepc_out  output  XLEN  current mepc
- mie_global  output  1  mstatus.MIE

Behaviour:
- Reset (rst=1 at posedge): mstatus.MIE=0, MPIE=0; mie, mscratch, mepc, mcause, mtval=0; mtvec=MTVEC_RESET; counters=0. Outputs follow: mtvec_out=MTVEC_RESET, mepc_out=0, mie_global=0. rst overrides every other input.
- Implemented CSRs:
  - 0x300 mstatus: MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11, other bits read 0.
  - 0x304 mie.
  - 0x305 mtvec, [1:0] read 0.
  - 0x340 mscratch.
  - 0x341 mepc, [1:0] read 0.
  - 0x342 mcause; 0x343 mtval.
  - 0xB00/0xB80 mcycle/mcycleh; 0xB02/0xB82 minstret/minstreth.
  - Read-only: 0xC00/0xC80/0xC02/0xC82 shadows; 0xF11-0xF13 read 0; 0xF14 reads HART_ID.
- Operand = csr_imm ? {27'b0,rs1_addr} : rs1_value.
- New value: RW=operand, RS=old|operand, RC=old&~operand.
- Write intent: RW always; RS/RC only when rs1_addr != 0.
- rd_value = old value whenever csr_valid, else 0. Zero latency.
- csr_illegal = csr_valid & op!=0 & (address unimplemented | (csr_addr[11:10]==2'b11 & write intent)).
  - Read of RO CSR with RS/RC and rs1_addr=0 is legal.
  - Illegal suppresses the write. rd_value is still driven (0 for unimplemented).
- Write commits at posedge when csr_valid & write intent & !csr_illegal & !trap_enter.
- Counters:
  - mcycle increments by 1 every non-reset cycle.
  - minstret increments when instr_retire.
  - Both wrap from all-ones to 0 (full COUNTER_WIDTH).
  - A CSR write to either half replaces that half; that counter does not increment that cycle (write wins).
- Trap entry (trap_enter=1):
  - mepc<=trap_pc with [1:0] cleared; mcause<=trap_cause; mtval<=trap_val.
  - MPIE<=MIE, MIE<=0.
  - Concurrent CSR write dropped. Counters still count.
- MRET (mret=1, trap_enter=0): MIE<=MPIE, MPIE<=1.
- trap_enter and mret together: trap wins, mret ignored.
- CSR write to mstatus and mret together: mret wins for MIE/MPIE.

Test Plan:
- Reset, then read 0x305 (CSRRS, rs1_addr=0) -> rd_value=MTVEC_RESET, no write, csr_illegal=0; read 0xF14 -> HART_ID.
- CSRRW mscratch rs1_value=0xDEAD_BEEF, then CSRRC with rs1_value=0x0000_00FF -> second rd_value=0xDEAD_BEEF; mscratch then reads 0xDEAD_BE00.
- CSRRWI 0xC00 uimm=5 -> csr_illegal=1, cycle unchanged; CSRRS 0xC00 rs1_addr=0 -> legal; access 0x7C0 -> illegal, rd_value=0.
- Write mcycle=0xFFFF_FFFF, mcycleh=0 -> next cycle mcycleh=1, mcycle=0; instr_retire with concurrent minstret write of 7 -> minstret=7.
- Set MIE=1; trap_enter with trap_pc=0x103, cause=0x8000_000B, concurrent CSRRW mscratch -> mepc=0x100, mcause=0x8000_000B, MIE=0, MPIE=1, mscratch unchanged.
- mret -> MIE=1, MPIE=1. rst asserted mid-sequence -> all state at reset values next cycle.
